// File: rtl/fc_weight_fetch.sv
// fc_weight_fetch: streams word pairs from a dual-port weight ROM through a 2-deep output FIFO.
// Defining FC_FETCH_PERF_EN adds the stall_cycles back-pressure counter output.
module fc_weight_fetch #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] pair_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_a,
    output logic [DATA_W-1:0] w_b,
    output logic              w_last
`ifdef FC_FETCH_PERF_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int EW = 2 * DATA_W + 1;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] next_q, next_d, rem_q, rem_d, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [ADDR_W-1:0] cur, avail;
    logic infl_q, infl_d, infl_last_q, infl_last_d, done_q, done_d;
    logic [1:0] occ_q, occ_d;
    logic [2:0] occ_eff;
    logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d, push_data;
    logic idle, accept, pop, push, issue, complete;
    always_comb begin
        idle        = state_q == IDLE;
        accept      = idle && start;
        pop         = w_valid && w_ready;
        push        = infl_q;
        push_data   = {q_a, q_b, infl_last_q};
        avail       = accept ? pair_count : rem_q;
        cur         = accept ? base_addr : next_q;
        // occupancy after this cycle's pop plus the read in flight must leave room for one more
        occ_eff     = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
        issue       = reset_n && (accept || !idle) && avail != '0 && occ_eff < 3'd2;
        addr_a_d    = issue ? cur : addr_a_q;
        addr_b_d    = issue ? cur + ADDR_W'(1) : addr_b_q;
        next_d      = issue ? cur + ADDR_W'(2) : next_q;
        rem_d       = (accept || !idle) ? avail - ADDR_W'(issue) : rem_q;
        infl_d      = issue;
        infl_last_d = issue && rem_d == '0;
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
        ent0_d      = (pop && occ_q == 2'd2) ? ent1_q : (push && (occ_q == 2'd0 || pop)) ? push_data : ent0_q;
        ent1_d      = (push && occ_q == 2'd1 && !pop) ? push_data : ent1_q;
        complete    = !idle && rem_q == '0 && !infl_q && occ_q == {1'b0, pop};
        done_d      = complete;
        state_d     = complete ? IDLE : accept ? RUN : (state_q == RUN && rem_d == '0) ? DRAIN : state_q;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            next_q      <= '0;
            rem_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
            occ_q       <= 2'd0;
            ent0_q      <= '0;
            ent1_q      <= '0;
        end else begin
            state_q     <= state_d;
            next_q      <= next_d;
            rem_q       <= rem_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
            occ_q       <= occ_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
        end
    end
    assign busy      = !idle;
    assign done      = done_q;
    assign address_a = addr_a_d;
    assign address_b = addr_b_d;
    assign w_valid   = occ_q != 2'd0;
    assign {w_a, w_b, w_last} = ent0_q;
`ifdef FC_FETCH_PERF_EN
    logic [15:0] stall_q, stall_d;
    always_comb stall_d = accept ? 16'd0 : (w_valid && !w_ready && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    always_ff @(posedge clock) stall_q <= !reset_n ? 16'd0 : stall_d;
    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_fc_weight_fetch.sv
// tb_fc_weight_fetch: directed checks of fc_weight_fetch against a 1-cycle-latency ROM model.
module tb_fc_weight_fetch;
    logic clock = 1'b0;
    logic reset_n, start, w_ready;
    logic [8:0] base_addr, pair_count, address_a, address_b;
    logic [15:0] q_a, q_b, w_a, w_b;
    logic busy, done, w_valid, w_last;
`ifdef FC_FETCH_PERF_EN
    logic [15:0] stall_cycles;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fc_weight_fetch dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .pair_count(pair_count), .busy(busy), .done(done), .address_a(address_a),
        .address_b(address_b), .q_a(q_a), .q_b(q_b), .w_valid(w_valid), .w_ready(w_ready),
        .w_a(w_a), .w_b(w_b), .w_last(w_last)
`ifdef FC_FETCH_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [15:0] rom(input logic [8:0] a);
        return {7'b1010011, a};
    endfunction

    always @(posedge clock) begin
        q_a <= rom(address_a);
        q_b <= rom(address_b);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic kick(input logic [8:0] b, input logic [8:0] n);
        start = 1'b1;
        base_addr = b;
        pair_count = n;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (w_valid !== 1'b0) begin failures++; $display("FAIL reset_w_valid got=%b exp=0", w_valid); end
        checks++; if (w_last !== 1'b0) begin failures++; $display("FAIL reset_w_last got=%b exp=0", w_last); end
        checks++; if (w_a !== 16'h0 || w_b !== 16'h0) begin failures++; $display("FAIL reset_w_data got=%h/%h exp=0/0", w_a, w_b); end
        checks++; if (address_a !== 9'd0 || address_b !== 9'd0) begin failures++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", address_a, address_b); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_burst(input logic [8:0] b, input int n);
        w_ready = 1'b1;
        kick(b, 9'(n));
        checks++; if (busy !== 1'b1 || w_valid !== 1'b0) begin failures++; $display("FAIL burst_first_cycle busy=%b w_valid=%b exp=1/0", busy, w_valid); end
        checks++; if (address_a !== 9'(b + 2) || address_b !== 9'(b + 3)) begin failures++; $display("FAIL burst_addr got=%0d/%0d exp=%0d/%0d", address_a, address_b, 9'(b + 2), 9'(b + 3)); end
        for (int i = 0; i < n; i++) begin
            step();
            checks++; if (w_valid !== 1'b1) begin failures++; $display("FAIL burst_valid i=%0d got=%b exp=1", i, w_valid); end
            checks++; if (w_a !== rom(9'(b + 2 * i)) || w_b !== rom(9'(b + 2 * i + 1))) begin failures++; $display("FAIL burst_pair i=%0d got=%h/%h exp=%h/%h", i, w_a, w_b, rom(9'(b + 2 * i)), rom(9'(b + 2 * i + 1))); end
            checks++; if (w_last !== (i == n - 1)) begin failures++; $display("FAIL burst_last i=%0d got=%b exp=%b", i, w_last, i == n - 1); end
        end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin failures++; $display("FAIL burst_done done=%b busy=%b w_valid=%b exp=1/0/0", done, busy, w_valid); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL burst_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_zero_count();
        w_ready = 1'b1;
        kick(9'd77, 9'd0);
        checks++; if (busy !== 1'b1 || done !== 1'b0 || w_valid !== 1'b0) begin failures++; $display("FAIL zero_run busy=%b done=%b w_valid=%b exp=1/0/0", busy, done, w_valid); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin failures++; $display("FAIL zero_done done=%b busy=%b w_valid=%b exp=1/0/0", done, busy, w_valid); end
        step();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        bit stalled = 0;
        bit want_done = 0;
        bit finished = 0;
        logic [15:0] sa, sb;
        logic sl;
        w_ready = 1'b0;
        kick(9'd40, 9'd8);
        while (cyc < 200 && !finished) begin
            if (stalled) begin
                checks++; if (w_valid !== 1'b1 || w_a !== sa || w_b !== sb || w_last !== sl) begin failures++; $display("FAIL bp_hold idx=%0d got=%b %h/%h/%b exp=1 %h/%h/%b", idx, w_valid, w_a, w_b, w_last, sa, sb, sl); end
            end
            if (want_done) begin
                checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_done done=%b busy=%b exp=1/0", done, busy); end
                finished = 1;
            end else begin
                w_ready = 1'($urandom_range(0, 1));
                if (w_valid && w_ready) begin
                    checks++; if (idx >= 8 || w_a !== rom(9'(40 + 2 * idx)) || w_b !== rom(9'(41 + 2 * idx)) || w_last !== (idx == 7)) begin failures++; $display("FAIL bp_pair idx=%0d got=%h/%h/%b exp=%h/%h/%b", idx, w_a, w_b, w_last, rom(9'(40 + 2 * idx)), rom(9'(41 + 2 * idx)), idx == 7); end
                    idx++;
                    want_done = idx == 8;
                end
                stalled = w_valid && !w_ready;
                sa = w_a;
                sb = w_b;
                sl = w_last;
                step();
                cyc++;
            end
        end
        checks++; if (!finished || idx != 8) begin failures++; $display("FAIL bp_complete pairs=%0d finished=%0d exp=8/1", idx, finished); end
        w_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        w_ready = 1'b1;
        kick(9'd100, 9'd10);
        step();
        step();
        step();
        checks++; if (w_valid !== 1'b1 || w_a !== rom(9'd104)) begin failures++; $display("FAIL rm_third got=%b %h exp=1 %h", w_valid, w_a, rom(9'd104)); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || w_valid !== 1'b0 || w_last !== 1'b0) begin failures++; $display("FAIL rm_ctrl busy=%b done=%b w_valid=%b w_last=%b exp=0000", busy, done, w_valid, w_last); end
        checks++; if (w_a !== 16'h0 || w_b !== 16'h0 || address_a !== 9'd0 || address_b !== 9'd0) begin failures++; $display("FAIL rm_data got=%h/%h %0d/%0d exp=0/0 0/0", w_a, w_b, address_a, address_b); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (done !== 1'b0 || w_valid !== 1'b0) begin failures++; $display("FAIL rm_quiet i=%0d done=%b w_valid=%b exp=0/0", i, done, w_valid); end
        end
        kick(9'd16, 9'd1);
        step();
        checks++; if (w_valid !== 1'b1 || w_a !== rom(9'd16) || w_b !== rom(9'd17) || w_last !== 1'b1) begin failures++; $display("FAIL rm_fresh got=%b %h/%h/%b exp=1 %h/%h/1", w_valid, w_a, w_b, w_last, rom(9'd16), rom(9'd17)); end
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rm_fresh_done got=%b exp=1", done); end
        step();
    endtask

    task automatic test_start_ignored();
        w_ready = 1'b1;
        kick(9'd200, 9'd3);
        kick(9'd0, 9'd5);
        for (int i = 0; i < 3; i++) begin
            checks++; if (w_valid !== 1'b1 || w_a !== rom(9'(200 + 2 * i)) || w_b !== rom(9'(201 + 2 * i)) || w_last !== (i == 2)) begin failures++; $display("FAIL ign_pair i=%0d got=%b %h/%h/%b exp=1 %h/%h/%b", i, w_valid, w_a, w_b, w_last, rom(9'(200 + 2 * i)), rom(9'(201 + 2 * i)), i == 2); end
            step();
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", done); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (w_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ign_no_second_job i=%0d w_valid=%b busy=%b exp=0/0", i, w_valid, busy); end
        end
    endtask

`ifdef FC_FETCH_PERF_EN
    task automatic test_stall_count();
        w_ready = 1'b0;
        kick(9'd60, 9'd2);
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL stall_clear got=%0d exp=0", stall_cycles); end
        step();
        for (int i = 0; i < 5; i++) step();
        checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL stall_count got=%0d exp=5", stall_cycles); end
        checks++; if (w_valid !== 1'b1 || w_a !== rom(9'd60)) begin failures++; $display("FAIL stall_head got=%b %h exp=1 %h", w_valid, w_a, rom(9'd60)); end
        w_ready = 1'b1;
        for (int i = 0; i < 10 && busy; i++) step();
        checks++; if (busy !== 1'b0 || stall_cycles !== 16'd5) begin failures++; $display("FAIL stall_final busy=%b stall=%0d exp=0/5", busy, stall_cycles); end
        step();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        base_addr = 9'd0;
        pair_count = 9'd0;
        w_ready = 1'b0;
        test_reset();
        test_burst(9'd0, 4);
        test_burst(9'd510, 2);
        test_zero_count();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
`ifdef FC_FETCH_PERF_EN
        test_stall_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fc_weight_fetch.md
FC_WEIGHT_FETCH -- requirements
Module: fc_weight_fetch

Interface
REQ-001 Parameter: ADDR_W, default 9, meaning weight ROM address width.
REQ-002 Parameter: DATA_W, default 16, meaning weight word width.
REQ-003 Port: clock  input  1  sole clock; all logic on posedge.
REQ-004 Port: reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port: start  input  1  job request; sampled only in IDLE.
REQ-006 Port: base_addr  input  ADDR_W  first word address of job.
REQ-007 Port: pair_count  input  ADDR_W  number of word pairs to fetch (0..2^(ADDR_W-1)).
REQ-008 Port: busy  output  1  high while not IDLE.
REQ-009 Port: done  output  1  one-cycle pulse at job completion.
REQ-010 Port: address_a, address_b  output  ADDR_W each  ROM read addresses.
REQ-011 Port: q_a, q_b  input  DATA_W each  ROM data, valid one clock after address.
REQ-012 Port: w_valid  output  1  output pair valid.
REQ-013 Port: w_ready  input  1  downstream accepts pair.
REQ-014 Port: w_a, w_b  output  DATA_W each  even/odd weight of pair.
REQ-015 Port: w_last  output  1  marks final pair of job.

Function
REQ-016 States IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after last address pair issued; DRAIN->IDLE when last pair accepted.
REQ-017 On start in IDLE the block SHALL latch base_addr and pair_count; start outside IDLE SHALL be ignored.
REQ-018 Pair i SHALL drive address_a = base_addr+2i, address_b = base_addr+2i+1, both modulo 2^ADDR_W (wrap-around, no error).
REQ-019 ROM read latency is exactly 1 cycle; q_a/q_b captured the cycle after issue.
REQ-020 Output path SHALL be a 2-entry FIFO of {w_a,w_b,w_last}; a pair is issued only when occupancy plus in-flight reads is below 2, so no data is ever dropped.
REQ-021 With w_ready held high, the block SHALL sustain one pair per cycle; first w_valid 2 cycles after start.
REQ-022 w_valid, once high, SHALL stay high with stable w_a/w_b/w_last until w_valid&&w_ready.
REQ-023 Pairs SHALL emerge in ascending i order; w_last high only with pair pair_count-1.
REQ-024 done SHALL pulse the cycle after the last pair handshake; busy falls in the same cycle done pulses.
REQ-025 pair_count=0: enter RUN, issue no addresses, no w_valid, done pulses 2 cycles after start.
REQ-026 Simultaneous FIFO push and pop at occupancy 2 SHALL NOT occur by REQ-020; at occupancy 1 it SHALL keep occupancy 1.
REQ-027 address_a/address_b SHALL hold last value when not issuing.

Reset
REQ-028 reset_n low at a clock edge SHALL force IDLE, FIFO empty, in-flight read discarded.
REQ-029 Reset values: busy=0, done=0, w_valid=0, w_last=0, w_a=w_b=0, address_a=address_b=0.
REQ-030 Reset mid-job SHALL abort without done pulse; next start after release SHALL behave as fresh job.

Configuration
REQ-031 Macro FC_FETCH_PERF_EN defined: add output stall_cycles[15:0], counting cycles with w_valid&&!w_ready, saturating at 0xFFFF, cleared by reset and on accepted start.
REQ-032 Macro FC_FETCH_PERF_EN undefined: stall_cycles port and counter absent; all other behaviour identical.

Verification
REQ-033 base=0, count=4, w_ready=1 -> pairs (rom[0],rom[1])..(rom[6],rom[7]) on consecutive cycles, w_last on 4th, done 1 cycle later.
REQ-034 base=510, count=2 -> pairs (rom[510],rom[511]),(rom[0],rom[1]) with wrap.
REQ-035 count=8, w_ready toggled randomly (50%) -> all 8 pairs in order, no loss or duplication, outputs stable while stalled.
REQ-036 count=0 -> no w_valid, done pulse 2 cycles after start.
REQ-037 reset_n low after 3 of 10 pairs -> all outputs at reset values next cycle, no done; new job base=16,count=1 then returns (rom[16],rom[17]) with w_last.
REQ-038 start pulsed during busy -> ignored, current job unchanged; with FC_FETCH_PERF_EN, w_ready=0 for 5 cycles while valid -> stall_cycles=5.
